// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round constants, MixColumns and ShiftRows helpers.
// Byte i of a 128-bit block sits at bits [127-8i -: 8], with row i%4 and column i/4.
package aes_pkg;

  localparam int unsigned BLK_W   = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned RND_W   = 4;
  localparam int unsigned NB      = 4;
  localparam int unsigned NR      = 10;
  localparam int unsigned FSM_W   = 2;

  typedef logic [FSM_W-1:0] fsm_t;

  localparam fsm_t ST_IDLE  = 2'd0;
  localparam fsm_t ST_ROUND = 2'd1;
  localparam fsm_t ST_DONE  = 2'd2;

  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NR);

  // Round constant for the key schedule, indexed by round number 1..10
  function automatic logic [BYTE_W-1:0] rcon(input logic [RND_W-1:0] rnd);
    logic [BYTE_W-1:0] r;
    r = 8'h00;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the {02 03 01 01} circulant matrix; row 0 in the MSB byte
  function automatic logic [WORD_W-1:0] mix_column(input logic [WORD_W-1:0] col);
    logic [BYTE_W-1:0] a0, a1, a2, a3;
    logic [BYTE_W-1:0] r0, r1, r2, r3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  // Source byte index feeding output byte i of forward ShiftRows
  function automatic int shift_src(input int i);
    int r;
    int c;
    r = i % 4;
    c = i / 4;
    return r + 4 * ((c + r) % 4);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational lookup.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry 0 occupies the most significant byte
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = TBL[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key expansion,
// valid/ready handshakes on both sides.
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  fsm_t              fsm, fsm_n;
  logic [RND_W-1:0]  round_reg, round_n;
  logic [BLK_W-1:0]  state_reg, state_n;
  logic [BLK_W-1:0]  rk_reg, rk_n;

  logic [BLK_W-1:0]  sb_state;
  logic [BLK_W-1:0]  sr_state;
  logic [BLK_W-1:0]  mc_state;
  logic [BLK_W-1:0]  rk_next;
  logic [WORD_W-1:0] rot_w, sub_w;
  logic [WORD_W-1:0] w4, w5, w6, w7;

  // SubBytes on every state byte, then ShiftRows as pure rewiring
  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .din  (state_reg[127-8*i -: 8]),
      .dout (sb_state[127-8*i -: 8])
    );
    assign sr_state[127-8*i -: 8] = sb_state[127-8*shift_src(i) -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc_state[127-32*c -: 32] = mix_column(sr_state[127-32*c -: 32]);
  end

  // Next round key from the current one: RotWord/SubWord on w3, then the xor chain
  assign rot_w = {rk_reg[23:0], rk_reg[31:24]};

  for (genvar k = 0; k < 4; k++) begin : g_key_sbox
    aes_sbox u_sbox (
      .din  (rot_w[31-8*k -: 8]),
      .dout (sub_w[31-8*k -: 8])
    );
  end

  assign w4      = rk_reg[127:96] ^ sub_w ^ {rcon(round_reg), 24'h000000};
  assign w5      = rk_reg[95:64]  ^ w4;
  assign w6      = rk_reg[63:32]  ^ w5;
  assign w7      = rk_reg[31:0]   ^ w6;
  assign rk_next = {w4, w5, w6, w7};

  // Next-state and datapath update
  always_comb begin
    fsm_n     = fsm;
    round_n   = round_reg;
    state_n   = state_reg;
    rk_n      = rk_reg;
    case (fsm)
      ST_IDLE: begin
        if (in_valid) begin
          state_n = plaintext ^ key;
          rk_n    = key;
          round_n = RND_W'(1);
          fsm_n   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        rk_n    = rk_next;
        round_n = round_reg + RND_W'(1);
        if (round_reg == LAST_ROUND) begin
          state_n = sr_state ^ rk_next;
          fsm_n   = ST_DONE;
        end else begin
          state_n = mc_state ^ rk_next;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_n = ST_IDLE;
        end
      end
      default: begin
        fsm_n = ST_IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they track fsm exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= ST_IDLE;
      round_reg <= '0;
      state_reg <= '0;
      rk_reg    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      fsm       <= fsm_n;
      round_reg <= round_n;
      state_reg <= state_n;
      rk_reg    <= rk_n;
      in_ready  <= (fsm_n == ST_IDLE);
      out_valid <= (fsm_n == ST_DONE);
      busy      <= (fsm_n != ST_IDLE);
    end
  end

  assign ciphertext = state_reg;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Scoreboard bench for aes_encrypt_iter: a textbook AES-128 model (S-box derived from
// GF(2^8) inversion) predicts each accepted job; a monitor checks every output handshake.
module tb_aes_encrypt_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int acc_edge    = 0;
  bit rec_acc     = 0;

  logic [127:0] exp_q[$];
  int           acc_q[$];

  logic [7:0] sb_t[256];
  logic [7:0] isb_t[256];

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_encrypt_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      if (a != 0)
        for (int b = 1; b < 256; b++)
          if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb_t[a]  = s;
      isb_t[s] = 8'(a);
    end
  end

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [1407:0] ws;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ws[1407-32*i -: 32] = w[i];
    return ws;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [1407:0] ws;
    logic [7:0] s[16];
    logic [7:0] t[16];
    logic [7:0] a[4];
    logic [127:0] r;
    ws = expand(k);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ws[1407-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_t[s[i]];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          for (int rr = 0; rr < 4; rr++) a[rr] = s[rr+4*c];
          for (int rr = 0; rr < 4; rr++)
            s[rr+4*c] = gmul(8'h02, a[rr]) ^ gmul(8'h03, a[(rr+1)%4]) ^ a[(rr+2)%4] ^ a[(rr+3)%4];
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ws[1407-128*rnd-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] k);
    logic [1407:0] ws;
    logic [7:0] s[16];
    logic [7:0] t[16];
    logic [7:0] a[4];
    logic [127:0] r;
    ws = expand(k);
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ ws[1407-1280-8*i -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) t[rr+4*((c+rr)%4)] = s[rr+4*c];
      for (int i = 0; i < 16; i++) s[i] = isb_t[t[i]] ^ ws[1407-128*rnd-8*i -: 8];
      if (rnd > 0)
        for (int c = 0; c < 4; c++) begin
          for (int rr = 0; rr < 4; rr++) a[rr] = s[rr+4*c];
          for (int rr = 0; rr < 4; rr++)
            s[rr+4*c] = gmul(8'h0e, a[rr]) ^ gmul(8'h0b, a[(rr+1)%4]) ^
                        gmul(8'h0d, a[(rr+2)%4]) ^ gmul(8'h09, a[(rr+3)%4]);
        end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk_int({name, "_in_ready"},  int'(in_ready),  1);
    chk_int({name, "_out_valid"}, int'(out_valid), 0);
    chk_int({name, "_busy"},      int'(busy),      0);
    chk128({name, "_ct"}, ciphertext, 128'h0);
  endtask

  // Scoreboard push: the accept happens at the posedge following this negedge
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(model_enc(plaintext, key));
      if (rec_acc) acc_q.push_back(cyc + 1);
    end
  end

  // Monitor: every output handshake pops one expected ciphertext
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got %h expected no output", ciphertext);
      end else begin
        chk128("scoreboard_ct", ciphertext, exp_q.pop_front());
      end
    end
  end

  // Present a job from a post-edge point; returns edges waited before acceptance
  task automatic issue(input logic [127:0] p, input logic [127:0] k, output int waited);
    plaintext = p;
    key       = k;
    in_valid  = 1'b1;
    waited    = 0;
    while (!in_ready && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) chk_int("accept_timeout", 0, 1);
    @(posedge clk); #1;
    acc_edge = cyc;
    in_valid = 1'b0;
  endtask

  // Latency counted in rising edges, the accepting edge included
  task automatic wait_done(output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (out_valid) lat = cyc - acc_edge + 1;
    else lat = -1;
  endtask

  initial begin
    int w;
    int lat;
    logic [127:0] ct0;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    plaintext = '0; key = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");

    // Release and accept on the very first edge
    rst_n = 1'b1;
    issue(P1, K1, w);
    chk_int("first_accept_wait", w, 0);
    chk_int("busy_after_accept", int'(busy), 1);
    wait_done(lat);
    chk_int("latency", lat, 11);
    chk128("ct_vec1", ciphertext, C1);
    @(posedge clk); #1;
    chk_int("idle_after_vec1", int'(in_ready), 1);

    // Second vector under 20 cycles of backpressure
    out_ready = 1'b0;
    issue(P2, K2, w);
    wait_done(lat);
    chk_int("latency_vec2", lat, 11);
    ct0 = ciphertext;
    chk128("ct_vec2", ct0, C2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid || ciphertext !== C2 || in_ready) begin
        chk_int("bp_out_valid", int'(out_valid), 1);
        chk128("bp_ct", ciphertext, C2);
        chk_int("bp_in_ready", int'(in_ready), 0);
      end else begin
        vectors++;
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_int("bp_release_in_ready", int'(in_ready), 1);
    chk_int("bp_release_out_valid", int'(out_valid), 0);
    chk128("round_trip", model_dec(ct0, K2), P2);

    // Abort a job at round 5 with an asynchronous reset
    issue(P1, K1, w);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midjob_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(P1, K1, w);
    wait_done(lat);
    chk_int("latency_after_reset", lat, 11);
    chk128("ct_after_reset", ciphertext, C1);
    @(posedge clk); #1;

    // in_valid held high with changing data: back-to-back jobs at 12-edge spacing
    rec_acc = 1'b1;
    for (int i = 0; i < 74; i++) begin
      in_valid  = 1'b1;
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rec_acc  = 1'b0;
    chk_int("b2b_accept_count", acc_q.size(), 7);
    for (int i = 1; i < acc_q.size(); i++)
      chk_int("b2b_spacing", acc_q[i] - acc_q[i-1], 12);

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || !in_ready); i++) begin
      @(posedge clk); #1;
    end
    chk_int("drain_pending", exp_q.size(), 0);
    chk_int("drain_idle", int'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
